// File: rtl/xdrop_extender_pkg.sv
// rtl/xdrop_extender_pkg.sv - shared types and constants for the ungapped X-drop extension stage
package xdrop_extender_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXTEND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] REASON_XDROP  = 2'd0;
  localparam logic [1:0] REASON_LAST   = 2'd1;
  localparam logic [1:0] REASON_MAXLEN = 2'd2;

  // Shared with the selector/adder stage feeding this block.
  localparam int DEFAULT_STEP_W = 3;
  localparam int DEFAULT_XDROP  = 10;

endpackage

// File: rtl/xdrop_extender_sat_add.sv
// rtl/xdrop_extender_sat_add.sv - signed saturating add of a score and a sign-extended step
module xdrop_extender_sat_add #(
  parameter int SCORE_W = 16,
  parameter int STEP_W  = 3
) (
  input  logic signed [SCORE_W-1:0] a,
  input  logic signed [STEP_W-1:0]  b,
  output logic signed [SCORE_W-1:0] sum
);

  localparam logic signed [SCORE_W-1:0] MAX_V = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic signed [SCORE_W-1:0] MIN_V = {1'b1, {(SCORE_W-1){1'b0}}};

  logic signed [SCORE_W:0] wide;

  // One guard bit: the top two bits disagree exactly when the true sum left the range.
  always_comb begin
    wide = {a[SCORE_W-1], a} + {{(SCORE_W+1-STEP_W){b[STEP_W-1]}}, b};
    if (wide[SCORE_W] != wide[SCORE_W-1]) begin
      sum = wide[SCORE_W] ? MIN_V : MAX_V;
    end else begin
      sum = wide[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/xdrop_extender.sv
// rtl/xdrop_extender.sv - seed extension with best-score tracking and X-drop/last/maxlen termination
module xdrop_extender
  import xdrop_extender_pkg::*;
#(
  parameter int STEP_W  = DEFAULT_STEP_W,
  parameter int SCORE_W = 16,
  parameter int LEN_W   = 10,
  parameter int XDROP   = DEFAULT_XDROP,
  parameter int MAX_LEN = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [SCORE_W-1:0] seed_score,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic        [STEP_W-1:0]  in_step,
  input  logic                      in_last,
  output logic                      busy,
  output logic                      done,
  output logic signed [SCORE_W-1:0] best_score,
  output logic        [LEN_W-1:0]   best_len,
  output logic        [1:0]         reason
);

  localparam logic signed [SCORE_W:0] XDROP_V   = (SCORE_W+1)'(XDROP);
  localparam logic        [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  state_t state, state_n;

  logic signed [SCORE_W-1:0] acc, acc_n, best_after;
  logic        [LEN_W-1:0]   len, len_n;
  logic signed [SCORE_W:0]   drop;
  logic                      accept, improve, terminate;
  logic        [1:0]         win_reason;

  xdrop_extender_sat_add #(
    .SCORE_W(SCORE_W),
    .STEP_W (STEP_W)
  ) u_sat_add (
    .a  (acc),
    .b  (in_step),
    .sum(acc_n)
  );

  // Termination is judged on the post-step values so a step can end the extension it belongs to.
  always_comb begin
    accept     = in_valid && (state == EXTEND);
    len_n      = len + 1'b1;
    improve    = acc_n > best_score;
    best_after = improve ? acc_n : best_score;
    drop       = {best_after[SCORE_W-1], best_after} - {acc_n[SCORE_W-1], acc_n};
    terminate  = 1'b1;
    win_reason = REASON_XDROP;
    if (drop >= XDROP_V) begin
      win_reason = REASON_XDROP;
    end else if (in_last) begin
      win_reason = REASON_LAST;
    end else if (len_n == MAX_LEN_V) begin
      win_reason = REASON_MAXLEN;
    end else begin
      terminate = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = EXTEND;
      EXTEND:  if (accept && terminate) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == EXTEND);
    busy     = (state == EXTEND) || (state == DONE);
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      len        <= '0;
      best_score <= '0;
      best_len   <= '0;
      reason     <= '0;
    end else if (state == IDLE && start) begin
      acc        <= seed_score;
      len        <= '0;
      best_score <= seed_score;
      best_len   <= '0;
    end else if (accept) begin
      acc <= acc_n;
      len <= len_n;
      if (improve) begin
        best_score <= acc_n;
        best_len   <= len_n;
      end
      if (terminate) reason <= win_reason;
    end
  end

endmodule

// File: tb/tb_xdrop_extender.sv
// tb/tb_xdrop_extender.sv - three parameterisations of xdrop_extender checked against a behavioural model
module tb_xdrop_extender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  start_v, valid_v, last_v;
  logic [15:0] seed_a [3];
  logic [2:0]  step_a [3];

  logic [2:0]         ready_v, busy_v, done_v;
  logic signed [15:0] bs0, bs1;
  logic signed [3:0]  bs2;
  logic [9:0]         bl0, bl1, bl2;
  logic [1:0]         r0, r1, r2;

  xdrop_extender dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .seed_score(seed_a[0]),
    .in_valid(valid_v[0]), .in_ready(ready_v[0]), .in_step(step_a[0]), .in_last(last_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .best_score(bs0), .best_len(bl0), .reason(r0)
  );

  xdrop_extender #(.XDROP(3), .MAX_LEN(5)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .seed_score(seed_a[1]),
    .in_valid(valid_v[1]), .in_ready(ready_v[1]), .in_step(step_a[1]), .in_last(last_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .best_score(bs1), .best_len(bl1), .reason(r1)
  );

  xdrop_extender #(.SCORE_W(4), .XDROP(3), .MAX_LEN(5)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .seed_score(seed_a[2][3:0]),
    .in_valid(valid_v[2]), .in_ready(ready_v[2]), .in_step(step_a[2]), .in_last(last_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .best_score(bs2), .best_len(bl2), .reason(r2)
  );

  int xd_p [3] = '{10, 3, 3};
  int ml_p [3] = '{1023, 5, 5};
  int smax [3] = '{32767, 32767, 7};
  int smin [3] = '{-32768, -32768, -8};

  // Model: phase 0 waiting for start, 1 extending, 2 reporting.
  int ph [3], acc_m [3], len_m [3], best_m [3], blen_m [3], rsn_m [3];
  bit started = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  function automatic int o_bs(int k);
    if (k == 0) return int'(bs0);
    if (k == 1) return int'(bs1);
    return int'(bs2);
  endfunction

  function automatic int o_bl(int k);
    if (k == 0) return int'(bl0);
    if (k == 1) return int'(bl1);
    return int'(bl2);
  endfunction

  function automatic int o_r(int k);
    if (k == 0) return int'(r0);
    if (k == 1) return int'(r1);
    return int'(r2);
  endfunction

  function automatic int seed_val(int k);
    logic signed [3:0]  s4;
    logic signed [15:0] s16;
    s4  = seed_a[k][3:0];
    s16 = seed_a[k];
    return (k == 2) ? int'(s4) : int'(s16);
  endfunction

  task automatic chk(string nm, int k, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s dut%0d got %0d expected %0d at %0t", nm, k, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          ph[k] = 0; acc_m[k] = 0; len_m[k] = 0; best_m[k] = 0; blen_m[k] = 0; rsn_m[k] = 0;
        end else if (ph[k] == 0) begin
          if (start_v[k]) begin
            acc_m[k] = seed_val(k); best_m[k] = seed_val(k);
            len_m[k] = 0; blen_m[k] = 0; ph[k] = 1;
          end
        end else if (ph[k] == 1) begin
          if (valid_v[k]) begin
            logic signed [2:0] s3;
            int a;
            s3 = step_a[k];
            a  = acc_m[k] + int'(s3);
            if (a > smax[k]) a = smax[k];
            if (a < smin[k]) a = smin[k];
            acc_m[k] = a;
            len_m[k] = len_m[k] + 1;
            if (a > best_m[k]) begin best_m[k] = a; blen_m[k] = len_m[k]; end
            if (best_m[k] - a >= xd_p[k]) begin rsn_m[k] = 0; ph[k] = 2; end
            else if (last_v[k]) begin rsn_m[k] = 1; ph[k] = 2; end
            else if (len_m[k] == ml_p[k]) begin rsn_m[k] = 2; ph[k] = 2; end
          end
        end else begin
          ph[k] = 0;
        end
      end
      started = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 3; k++) begin
          chk("in_ready", k, int'(ready_v[k]), int'(ph[k] == 1));
          chk("busy", k, int'(busy_v[k]), int'(ph[k] != 0));
          chk("done", k, int'(done_v[k]), int'(ph[k] == 2));
          chk("best_score", k, o_bs(k), best_m[k]);
          chk("best_len", k, o_bl(k), blen_m[k]);
          chk("reason", k, o_r(k), rsn_m[k]);
        end
      end
    end
  end

  task automatic do_start(int k, int sd);
    seed_a[k] = 16'(sd);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic step_in(int k, int s, bit l, int gap);
    int t;
    t = 0;
    valid_v[k] = 1'b1;
    step_a[k] = 3'(s);
    last_v[k] = l;
    while (!ready_v[k] && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) chk("ready_timeout", k, 0, 1);
    @(negedge clk);
    valid_v[k] = 1'b0;
    last_v[k] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic finish_ext(string nm, int k, int exp_bs, int exp_bl, int exp_r);
    int t;
    t = 0;
    while (!done_v[k] && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk({nm, "_done_timeout"}, k, 0, 1);
    chk({nm, "_best_score"}, k, o_bs(k), exp_bs);
    chk({nm, "_best_len"}, k, o_bl(k), exp_bl);
    chk({nm, "_reason"}, k, o_r(k), exp_r);
    @(negedge clk);
  endtask

  initial begin
    int t, k, sd, r;
    bit bias;
    rst = 1'b1;
    start_v = '0; valid_v = '0; last_v = '0;
    for (int i = 0; i < 3; i++) begin seed_a[i] = '0; step_a[i] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_busy", 0, int'(busy_v[0]), 0);
    chk("reset_best_score", 0, o_bs(0), 0);
    rst = 1'b0;
    @(negedge clk);

    do_start(1, 0);
    for (int i = 0; i < 5; i++) step_in(1, 2, 1'b0, 0);
    finish_ext("pure_match", 1, 10, 5, 2);

    do_start(1, 0);
    step_in(1, 2, 1'b0, 0); step_in(1, 2, 1'b0, 0);
    step_in(1, -1, 1'b0, 0); step_in(1, -1, 1'b0, 0); step_in(1, -1, 1'b0, 0);
    finish_ext("xdrop", 1, 4, 2, 0);

    do_start(1, 5);
    step_in(1, -1, 1'b0, 0); step_in(1, -1, 1'b0, 0); step_in(1, -1, 1'b1, 0);
    finish_ext("last_and_drop", 1, 5, 0, 0);

    do_start(0, 20);
    step_in(0, 1, 1'b0, 0);
    seed_a[0] = 16'd100;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("busy_in_gap", 0, int'(busy_v[0]), 1);
    repeat (2) @(negedge clk);
    step_in(0, 1, 1'b0, 3);
    step_in(0, 0, 1'b1, 0);
    finish_ext("backpressure", 0, 22, 2, 1);

    do_start(2, 6);
    step_in(2, 3, 1'b0, 0); step_in(2, 3, 1'b1, 0);
    finish_ext("saturate", 2, 7, 1, 1);

    do_start(0, 7);
    step_in(0, 2, 1'b0, 0); step_in(0, -1, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 0, int'(busy_v[0]), 0);
    chk("midrst_best_score", 0, o_bs(0), 0);
    chk("midrst_best_len", 0, o_bl(0), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 0, int'(done_v[0]), 0);
    end
    do_start(0, -3);
    step_in(0, 1, 1'b0, 0); step_in(0, 1, 1'b0, 0); step_in(0, 0, 1'b1, 0);
    finish_ext("after_reset", 0, -1, 2, 1);

    for (int i = 0; i < 45; i++) begin
      k = i % 3;
      bias = (i % 7 == 0) || (k == 2 && i % 2 == 0);
      if (k == 2) sd = int'($urandom_range(0, 15)) - 8;
      else if (i % 7 == 0) sd = 32760;
      else sd = int'($urandom_range(0, 200)) - 100;
      do_start(k, sd);
      t = 0;
      while (!done_v[k] && t < 3000) begin
        valid_v[k] = ($urandom_range(0, 3) != 0);
        r = int'($urandom_range(0, 7));
        step_a[k] = (bias && r < 6) ? 3'd3 : 3'(r);
        last_v[k] = ($urandom_range(0, 39) == 0);
        @(negedge clk);
        t++;
      end
      valid_v[k] = 1'b0;
      last_v[k] = 1'b0;
      if (t >= 3000) chk("random_done_timeout", k, 0, 1);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xdrop_extender.md
Name: xdrop_extender

Overview:
- Ungapped-extension stage of the Blastn datapath; sits directly downstream of the selector/adder stage and consumes its signed per-position step score.
- Accumulates the running alignment score from a seed, tracks the best score and the length at which it occurred, and terminates on X-drop, end of sequence, or maximum length.
- Reports the best score, best length and termination reason to the hit-reporting logic.

Parameters:
- STEP_W, 3, width of signed per-position step score (two's complement).
- SCORE_W, 16, width of signed accumulator and best score.
- LEN_W, 10, width of length counters.
- XDROP, 10, positive drop threshold; terminate when best minus current reaches or exceeds XDROP.
- MAX_LEN, 1023, maximum number of extension steps; must fit LEN_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin extension; sampled only in IDLE.
- seed_score  in  SCORE_W  signed initial score, loaded on start.
- in_valid  in  1  step score valid.
- in_ready  out  1  stage accepts a step this cycle.
- in_step  in  STEP_W  signed step score (selector/adder sum).
- in_last  in  1  marks the final position of the sequence.
- busy  out  1  high from accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse, result valid.
- best_score  out  SCORE_W  signed best accumulated score.
- best_len  out  LEN_W  steps consumed at best score (0 = seed only).
- reason  out  2  0 = xdrop, 1 = last, 2 = maxlen, 3 = unused.

Behaviour:
- Reset (synchronous, active-high; rst=1 at a rising edge):
  - state to IDLE.
  - in_ready, busy, done, best_score, best_len, reason all 0.
  - Internal acc and len cleared.
  - Reset mid-extension discards all progress; no done is emitted.
- States: IDLE, EXTEND, DONE.
- IDLE:
  - start=1 loads acc=best_score=seed_score and len=best_len=0, then goes to EXTEND.
  - start is ignored in every other state.
- EXTEND:
  - in_ready=1.
  - A step is accepted on in_valid & in_ready.
  - On accept:
    - acc_n = sat(acc + sext(in_step)).
    - len_n = len + 1.
    - If acc_n > best_score (strict), best_score = acc_n and best_len = len_n; ties keep the earlier, shorter length.
  - Termination test uses the updated values in the same cycle:
    - xdrop if best_after - acc_n >= XDROP.
    - else last if in_last=1.
    - else maxlen if len_n == MAX_LEN.
    - Priority is xdrop > last > maxlen; reason latches the winning code and state goes to DONE.
  - No accept means no change to state or values.
- DONE:
  - done=1 for exactly one cycle; in_ready=0.
  - Next state is IDLE.
  - best_score, best_len and reason hold until the next accepted start.
- Latency: done is asserted on the cycle after the terminating step is accepted.
- Throughput: one step per cycle; 2 dead cycles (DONE, IDLE) between extensions.
- Arithmetic:
  - in_step is sign-extended to SCORE_W.
  - acc saturates at the signed max and min of SCORE_W; it never wraps.
  - The drop difference is computed in SCORE_W+1 bits so it cannot overflow.
- len never exceeds MAX_LEN.
- An in_last arriving with in_valid=0 is ignored.

Decomposition:
- Shared package holds:
  - State enum (IDLE, EXTEND, DONE).
  - Reason codes (REASON_XDROP, REASON_LAST, REASON_MAXLEN).
  - Default XDROP and STEP_W constants, shared with the selector/adder stage.
- One natural sub-module, sat_add: a combinational signed saturating adder, SCORE_W plus sign-extended STEP_W.
- The FSM, best tracking and termination logic stay in xdrop_extender.

Test Plan:
- Pure matches:
  - Stimulus: seed 0, MAX_LEN=5, steps +2 ×5, in_last never set.
  - Response: done after 5th accept; best_score=10, best_len=5, reason=2.
- X-drop:
  - Stimulus: seed 0, XDROP=3, steps +2,+2,-1,-1,-1.
  - Response: terminates on the 5th step (4-1=3); best_score=4, best_len=2, reason=0.
- Last with simultaneous drop:
  - Stimulus: seed 5, XDROP=3, steps -1,-1,-1 with in_last on the 3rd.
  - Response: reason=0 (priority); best_score=5, best_len=0.
- Backpressure and idle:
  - Stimulus: in_valid gaps of 3 cycles between steps +1,+1 then in_last; start pulsed during EXTEND.
  - Response: start ignored; best_score=seed+2, reason=1; busy stays high throughout.
- Saturation:
  - Stimulus: SCORE_W=4, seed 6, steps +3,+3.
  - Response: acc clamps at 7; best_score=7, best_len=1; no wrap to negative.
- Reset mid-operation:
  - Stimulus: rst asserted after 2 accepted steps.
  - Response: next cycle in IDLE; all outputs 0; no done pulse; a fresh start then runs normally.
